fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 12'h000, SHALL be the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h00000013, SHALL be the bubble instruction driven when no valid instruction is present.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 stall  input  1  SHALL mean the downstream IF/ID register cannot accept; the IF_* outputs hold.
REQ-006 redirect_valid  input  1  SHALL mean a taken branch or jump from EX.
REQ-007 redirect_pc  input  12  SHALL be the redirect target; bits [1:0] are ignored and treated as 00.
REQ-008 imem_req  output  1  SHALL be the instruction memory request valid.
REQ-009 imem_addr  output  12  SHALL be the instruction memory word address, always 4-byte aligned.
REQ-010 imem_ack  input  1  SHALL mean imem_rdata is valid for the current request; it may assert in the same cycle as imem_req.
REQ-011 imem_rdata  input  32  SHALL be the instruction data, valid only with imem_ack.
REQ-012 IF_PC  output  12  SHALL be the PC of the presented instruction, registered.
REQ-013 IF_Instruction  output  32  SHALL be the presented instruction, registered.
REQ-014 IF_valid  output  1  SHALL be 1 when IF_PC and IF_Instruction hold a real fetched instruction.

Function
REQ-015 State machine SHALL have the states IDLE, REQ, HOLD and DRAIN, plus a 12-bit pc register and a 44-bit skid buffer (PC + instruction).
REQ-016 IDLE SHALL last exactly one cycle after reset, with imem_req=0, then go to REQ.
REQ-017 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc; address stays stable until imem_ack.
REQ-018 REQ with ack, stall=0, no redirect: IF_PC<=pc, IF_Instruction<=imem_rdata, IF_valid<=1, pc<=pc+4, and the unit stays in REQ, giving back-to-back fetches with 1-cycle throughput.
REQ-019 REQ with ack and stall=1: the response SHALL be captured in the skid buffer, pc<=pc+4, state<=HOLD, and the IF_* outputs remain unchanged.
REQ-020 REQ without ack and stall=0: IF_valid<=0 and IF_Instruction<=NOP_INSTR (bubble); IF_PC holds.
REQ-021 REQ without ack and stall=1: all IF_* outputs SHALL hold.
REQ-022 In HOLD, imem_req SHALL be 0; when stall=0 the skid buffer SHALL load the IF_* outputs with IF_valid<=1 and state<=REQ.
REQ-023 redirect_valid SHALL have priority over stall and ack in every state: pc<=redirect_pc & ~3, IF_valid<=0, IF_Instruction<=NOP_INSTR, IF_PC<=redirect_pc & ~3, and the skid buffer is invalidated.
REQ-024 A redirect in REQ with imem_req=1 and no ack in the same cycle SHALL go to DRAIN; a redirect in any other case SHALL go to REQ.
REQ-025 In DRAIN, imem_req SHALL stay 1 with the old address; the first ack is discarded and the unit then goes to REQ at the new pc.
REQ-026 pc arithmetic SHALL be modulo 2^12: 12'hFFC+4 wraps to 12'h000.
REQ-027 Outputs SHALL never change while stall=1, except on a redirect.

Reset
REQ-028 While rst=1: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, IF_PC=12'h000, IF_Instruction=NOP_INSTR, IF_valid=0, and the skid buffer is invalid.
REQ-029 rst SHALL override redirect_valid, stall and ack; assertion mid-request abandons the outstanding request, and any late ack after reset release is ignored until the next imem_req.

Verification
REQ-030 Zero-wait memory returning imem_rdata=addr, stall=0 -> after the IDLE cycle, IF_PC/IF_Instruction show 0/0, 4/4, 8/8, C/C on consecutive cycles with IF_valid=1.
REQ-031 stall=1 for 3 cycles while fetching addr 12'h008 -> outputs hold 4/4; 8/8 is buffered (imem_req=0 in HOLD); on stall release 8/8 appears the next cycle; no duplicate or lost instruction.
REQ-032 redirect_valid=1, redirect_pc=12'h103 during a 2-cycle-latency request to 12'h00C -> DRAIN, stale ack discarded, next imem_addr=12'h100, IF_valid=0 for the bubble cycle, then 12'h100 is presented.
REQ-033 redirect and stall asserted in the same cycle -> redirect wins, buffer flushed, IF_Instruction=32'h00000013, IF_valid=0.
REQ-034 Redirect to 12'hFF8, zero-wait memory -> fetch sequence FF8, FFC, 000, 004.
REQ-035 rst asserted mid-request with an ack arriving one cycle after release -> outputs stay at reset values, fetch restarts at RESET_PC, and the stray ack is ignored.

Source files
------------

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if -- instruction memory request/response bus.
//
// Signals:
//   imem_req   : request valid (fetch unit -> memory)
//   imem_addr  : 12-bit word-aligned fetch address (fetch unit -> memory)
//   imem_ack   : response valid, may assert in the same cycle as imem_req
//   imem_rdata : 32-bit instruction, meaningful only with imem_ack
//
// Modports:
//   master : fetch unit side (drives req/addr)
//   slave  : memory side (drives ack/rdata)
// ---------------------------------------------------------------------------
interface fetch_unit_if;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit -- instruction fetch stage with a one-entry skid buffer.
//
// Issues word-aligned requests to instruction memory and presents fetched
// instructions to the IF/ID boundary. A response arriving while downstream
// is stalled is parked in the skid buffer and released when the stall lifts.
// A redirect flushes everything; if a request is still outstanding, its
// stale response is drained and dropped before fetching the new target.
//
// Ports:
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset
//   stall          : downstream cannot accept; IF_* outputs hold
//   redirect_valid : taken branch/jump from EX
//   redirect_pc    : redirect target (bits [1:0] ignored)
//   imem           : instruction memory bus (master side)
//   IF_PC          : PC of the presented instruction
//   IF_Instruction : presented instruction (NOP_INSTR when no valid one)
//   IF_valid       : IF_PC/IF_Instruction hold a real fetched instruction
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [11:0] RESET_PC  = 12'h000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [11:0]  redirect_pc,
    fetch_unit_if.master imem,
    output logic [11:0]  IF_PC,
    output logic [31:0]  IF_Instruction,
    output logic         IF_valid
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    function automatic logic [11:0] align_word(input logic [11:0] a);
        return a & 12'hFFC;
    endfunction

    logic [1:0]  state;
    logic [11:0] pc;
    logic [11:0] drain_addr;
    logic [11:0] redirect_tgt;
    logic [11:0] pc_next_seq;

    logic [11:0] skid_pc_p0;
    logic [31:0] skid_instr_p0;
    logic        skid_vld_p0;
    logic        skid_load;

    assign redirect_tgt = align_word(redirect_pc);
    // 12-bit add wraps naturally: FFC + 4 -> 000.
    assign pc_next_seq  = pc + 12'd4;

    // While draining, the memory still sees the abandoned address so the
    // outstanding transaction completes unchanged.
    assign imem.imem_req  = !rst && ((state == REQ) || (state == DRAIN));
    assign imem.imem_addr = rst ? align_word(RESET_PC)
                          : ((state == DRAIN) ? drain_addr : pc);

    // Response accepted while stalled goes into the skid buffer.
    assign skid_load = !rst && !redirect_valid && (state == REQ)
                    && imem.imem_ack && stall;

    // Control and presented-instruction state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            pc             <= align_word(RESET_PC);
            drain_addr     <= align_word(RESET_PC);
            IF_PC          <= 12'h000;
            IF_Instruction <= NOP_INSTR;
            IF_valid       <= 1'b0;
            skid_vld_p0    <= 1'b0;
        end else if (redirect_valid) begin
            pc             <= redirect_tgt;
            IF_PC          <= redirect_tgt;
            IF_Instruction <= NOP_INSTR;
            IF_valid       <= 1'b0;
            skid_vld_p0    <= 1'b0;
            // Only an unanswered live request needs its response drained.
            if ((state == REQ) && !imem.imem_ack) begin
                state      <= DRAIN;
                drain_addr <= pc;
            end else begin
                state      <= REQ;
            end
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                end
                REQ: begin
                    if (imem.imem_ack) begin
                        pc <= pc_next_seq;
                        if (stall) begin
                            skid_vld_p0 <= 1'b1;
                            state       <= HOLD;
                        end else begin
                            IF_PC          <= pc;
                            IF_Instruction <= imem.imem_rdata;
                            IF_valid       <= 1'b1;
                        end
                    end else if (!stall) begin
                        IF_Instruction <= NOP_INSTR;
                        IF_valid       <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        IF_PC          <= skid_pc_p0;
                        IF_Instruction <= skid_instr_p0;
                        IF_valid       <= skid_vld_p0;
                        skid_vld_p0    <= 1'b0;
                        state          <= REQ;
                    end
                end
                DRAIN: begin
                    if (imem.imem_ack) begin
                        state <= REQ;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Skid buffer payload; validity is tracked by skid_vld_p0 above.
    always_ff @(posedge clk) begin
        if (skid_load) begin
            skid_pc_p0    <= pc;
            skid_instr_p0 <= imem.imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit -- directed bench for fetch_unit.
//
// A small memory responder either answers every request in the same cycle
// with rdata = address, or is driven by hand (man_ack/man_data) to create
// wait states and stray responses.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic [11:0] IF_PC;
    logic [31:0] IF_Instruction;
    logic        IF_valid;

    logic        zero_wait;
    logic        man_ack;
    logic [31:0] man_data;

    int vectors     = 0;
    int miscompares = 0;

    fetch_unit_if imem_bus ();

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem_bus),
        .IF_PC          (IF_PC),
        .IF_Instruction (IF_Instruction),
        .IF_valid       (IF_valid)
    );

    always #5 clk = ~clk;

    assign imem_bus.imem_ack   = zero_wait ? imem_bus.imem_req : man_ack;
    assign imem_bus.imem_rdata = zero_wait ? {20'h00000, imem_bus.imem_addr} : man_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_if(input string tag, input logic [11:0] pc_e,
                          input logic [31:0] ins_e, input logic vld_e);
        chk({tag, "_pc"},  {20'h0, IF_PC}, {20'h0, pc_e});
        chk({tag, "_ins"}, IF_Instruction, ins_e);
        chk({tag, "_vld"}, {31'h0, IF_valid}, {31'h0, vld_e});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 12'h000;
        zero_wait = 1'b1; man_ack = 1'b0; man_data = 32'h0;
        step; step;
        chk("rst_req",  {31'h0, imem_bus.imem_req}, 32'h0);
        chk("rst_addr", {20'h0, imem_bus.imem_addr}, 32'h0);
        chk_if("rst", 12'h000, 32'h00000013, 1'b0);

        // Back-to-back zero-wait fetches after the single IDLE cycle.
        rst = 1'b0;
        chk("idle_req", {31'h0, imem_bus.imem_req}, 32'h0);
        step;
        chk("req_req",  {31'h0, imem_bus.imem_req}, 32'h1);
        chk("req_addr", {20'h0, imem_bus.imem_addr}, 32'h0);
        chk("req_vld",  {31'h0, IF_valid}, 32'h0);
        step; chk_if("seq0", 12'h000, 32'h000, 1'b1);
        step; chk_if("seq4", 12'h004, 32'h004, 1'b1);
        step; chk_if("seq8", 12'h008, 32'h008, 1'b1);
        step; chk_if("seqC", 12'h00C, 32'h00C, 1'b1);

        // Wait state: bubble, IF_PC holds; request to 0x010 outstanding.
        zero_wait = 1'b0; man_ack = 1'b0;
        step;
        chk_if("bub", 12'h00C, 32'h00000013, 1'b0);
        chk("bub_addr", {20'h0, imem_bus.imem_addr}, 32'h010);

        // Reset mid-request, stray ack in the cycle after release.
        rst = 1'b1;
        step;
        chk_if("mrst", 12'h000, 32'h00000013, 1'b0);
        chk("mrst_req", {31'h0, imem_bus.imem_req}, 32'h0);
        step;
        rst = 1'b0; man_ack = 1'b1; man_data = 32'hDEADBEEF;
        chk("mrst_idle_req", {31'h0, imem_bus.imem_req}, 32'h0);
        step;
        man_ack = 1'b0; zero_wait = 1'b1;
        chk_if("stray", 12'h000, 32'h00000013, 1'b0);
        chk("stray_addr", {20'h0, imem_bus.imem_addr}, 32'h000);
        chk("stray_req",  {31'h0, imem_bus.imem_req}, 32'h1);
        step; chk_if("rs0", 12'h000, 32'h000, 1'b1);
        step; chk_if("rs4", 12'h004, 32'h004, 1'b1);

        // Three stall cycles while fetching 0x008.
        stall = 1'b1;
        step;
        chk("hold_req", {31'h0, imem_bus.imem_req}, 32'h0);
        chk_if("st1", 12'h004, 32'h004, 1'b1);
        step; chk_if("st2", 12'h004, 32'h004, 1'b1);
        step; chk_if("st3", 12'h004, 32'h004, 1'b1);
        stall = 1'b0;
        step; chk_if("skid8", 12'h008, 32'h008, 1'b1);
        step; chk_if("postC", 12'h00C, 32'h00C, 1'b1);

        // Redirect with a same-cycle ack: no drain, low bits masked.
        redirect_valid = 1'b1; redirect_pc = 12'h00E;
        step;
        redirect_valid = 1'b0;
        chk_if("rdA", 12'h00C, 32'h00000013, 1'b0);
        chk("rdA_addr", {20'h0, imem_bus.imem_addr}, 32'h00C);

        // 2-cycle-latency request to 0x00C, redirected before its ack.
        zero_wait = 1'b0; man_ack = 1'b0;
        step;
        chk("lat_vld",  {31'h0, IF_valid}, 32'h0);
        chk("lat_addr", {20'h0, imem_bus.imem_addr}, 32'h00C);
        redirect_valid = 1'b1; redirect_pc = 12'h103;
        step;
        redirect_valid = 1'b0;
        chk_if("drn", 12'h100, 32'h00000013, 1'b0);
        chk("drn_req",  {31'h0, imem_bus.imem_req}, 32'h1);
        chk("drn_addr", {20'h0, imem_bus.imem_addr}, 32'h00C);
        man_ack = 1'b1; man_data = 32'hBAD0BAD0;
        step;
        man_ack = 1'b0; zero_wait = 1'b1;
        chk_if("stale", 12'h100, 32'h00000013, 1'b0);
        chk("new_addr", {20'h0, imem_bus.imem_addr}, 32'h100);
        step; chk_if("t100", 12'h100, 32'h100, 1'b1);

        // Redirect and stall together while 0x104 sits in the skid buffer.
        stall = 1'b1;
        step;
        chk("hold2_req", {31'h0, imem_bus.imem_req}, 32'h0);
        chk_if("hold2", 12'h100, 32'h100, 1'b1);
        redirect_valid = 1'b1; redirect_pc = 12'hFF8;
        step;
        redirect_valid = 1'b0; stall = 1'b0;
        chk_if("rdst", 12'hFF8, 32'h00000013, 1'b0);
        chk("rdst_addr", {20'h0, imem_bus.imem_addr}, 32'hFF8);

        // Wrap-around fetch sequence.
        step; chk_if("wFF8", 12'hFF8, 32'hFF8, 1'b1);
        step; chk_if("wFFC", 12'hFFC, 32'hFFC, 1'b1);
        step; chk_if("w000", 12'h000, 32'h000, 1'b1);
        step; chk_if("w004", 12'h004, 32'h004, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
